// File: rtl/sram_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_reader
// Purpose  : Pop-side reader for a BRAM-backed FIFO; hides the read latency
//            behind a credit-limited skid buffer and emits a valid/ready
//            stream. Define SRAM_FIFO_READER_PERF_EN to build the stall counter.
// Revision : 1.0
// ============================================================================
module sram_fifo_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_pop_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [31:0]           stall_cnt_o
);

    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int c_PTR_W   = $clog2(BUF_DEPTH);
    localparam int c_CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(BUF_DEPTH - 1);
    localparam logic [7:0]         c_DEPTH8   = 8'(BUF_DEPTH);

    logic [READ_LATENCY-1:0] r_inflight;
    logic [READ_LATENCY-1:0] w_inflight_nxt;
    logic [DATA_WIDTH-1:0]   r_buf [BUF_DEPTH];
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_flush_q;
    logic [7:0]              w_credit_used;
    logic                    w_pop;
    logic                    w_wr_en;
    logic                    w_hs;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Every outstanding pop already owns a buffer slot, so popping never depends on ready_i.
    always_comb begin
        w_credit_used = 8'(r_cnt);
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_credit_used = w_credit_used + 8'(r_inflight[i]);
        end
    end

    assign w_pop      = !fifo_empty_i && !flush_i && !r_flush_q && (w_credit_used < c_DEPTH8);
    assign w_wr_en    = r_inflight[READ_LATENCY-1];
    assign valid_o    = (r_cnt != '0);
    assign w_hs       = valid_o && ready_i;
    assign data_o     = r_buf[r_rd_ptr];
    assign fifo_pop_o = w_pop;

    generate
        if (READ_LATENCY == 1) begin : g_shift_single
            assign w_inflight_nxt = w_pop;
        end else begin : g_shift_multi
            assign w_inflight_nxt = {r_inflight[READ_LATENCY-2:0], w_pop};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_inflight <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_flush_q  <= 1'b1;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_flush_q <= flush_i;
            if (flush_i) begin
                r_inflight <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_cnt      <= '0;
            end else begin
                r_inflight <= w_inflight_nxt;
                if (w_wr_en) begin
                    r_buf[r_wr_ptr] <= fifo_data_i;
                    r_wr_ptr        <= f_next_ptr(r_wr_ptr);
                end
                if (w_hs) begin
                    r_rd_ptr <= f_next_ptr(r_rd_ptr);
                end
                case ({w_wr_en, w_hs})
                    2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && w_wr_en && !w_hs) begin
            assert (r_cnt < c_CNT_W'(BUF_DEPTH));
        end
    end

`ifdef SRAM_FIFO_READER_PERF_EN
    logic [31:0] r_stall_cnt;

    // Survives flush on purpose: it measures consumer backpressure across the whole run.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (valid_o && !ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fifo_reader
// Purpose  : Drives latency-1 and latency-2 readers from one stimulus stream
//            and checks them against FIFO and in-order stream models.
// Revision : 1.0
// ============================================================================
module tb_sram_fifo_reader;

`ifdef SRAM_FIFO_READER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic        empty0 = 1'b1;
    logic        empty1 = 1'b1;
    logic [31:0] fdata0 = '0;
    logic [31:0] fdata1 = '0;
    logic        pop0, pop1, valid0, valid1;
    logic [31:0] data0, data1, stall0, stall1;

    always #5 clk = ~clk;

    sram_fifo_reader #(.DATA_WIDTH(32), .READ_LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fifo_empty_i(empty0),
        .fifo_pop_o(pop0), .fifo_data_i(fdata0), .valid_o(valid0), .ready_i(ready),
        .data_o(data0), .stall_cnt_o(stall0));

    sram_fifo_reader #(.DATA_WIDTH(32), .READ_LATENCY(2)) u_dut_l2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fifo_empty_i(empty1),
        .fifo_pop_o(pop1), .fifo_data_i(fdata1), .valid_o(valid1), .ready_i(ready),
        .data_o(data1), .stall_cnt_o(stall1));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] fq0[$];
    logic [31:0] fq1[$];
    logic [31:0] eq0[$];
    logic [31:0] eq1[$];
    logic [31:0] pipe1 = '0;
    int          outst[2];
    int          stall_m[2];
    logic        prev_valid[2];
    logic [31:0] prev_data[2];
    logic        prev_ready = 1'b0, prev_flush = 1'b0, prev_rstn = 1'b0;
    logic        flush_d = 1'b0, rst_d = 1'b1;
    logic        s_pop[2], s_valid[2];
    logic [31:0] s_data[2], s_stall[2];
    logic        s_rstn, s_flush, s_ready;

    typedef struct {
        logic        ready;
        logic        pop1;
        logic        val1;
        logic [31:0] d1;
        logic        pop2;
        logic        val2;
        logic [31:0] d2;
    } vec_t;
    vec_t vecs[22];

    task automatic fail(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_fail++;
        $display("FAIL %s L%0d cyc=%0d got=%h exp=%h", name, k + 1, cyc, got, exp);
    endtask

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) fail(name, k, got, exp);
    endtask

    task automatic push(input logic [31:0] w);
        fq0.push_back(w);
        fq1.push_back(w);
        eq0.push_back(w);
        eq1.push_back(w);
        empty0 = 1'b0;
        empty1 = 1'b0;
    endtask

    // Sample one cycle's outputs and apply the stream-level rules.
    task automatic sample();
        logic        emp;
        logic        have;
        logic [31:0] exp_w;
        #1;
        s_pop[0] = pop0;     s_pop[1] = pop1;
        s_valid[0] = valid0; s_valid[1] = valid1;
        s_data[0] = data0;   s_data[1] = data1;
        s_stall[0] = stall0; s_stall[1] = stall1;
        s_rstn = rst_n; s_flush = flush; s_ready = ready;
        for (int k = 0; k < 2; k++) begin
            emp = (k == 0) ? empty0 : empty1;
            if (s_rstn) begin
                if (s_pop[k] && emp) fail("pop_when_empty", k, 1, 0);
                if (s_pop[k] && (s_flush || flush_d || rst_d)) fail("pop_blocked", k, 1, 0);
                if (prev_valid[k] && !prev_ready && !prev_flush && prev_rstn) begin
                    if (!s_valid[k] || s_data[k] !== prev_data[k]) fail("hold", k, s_data[k], prev_data[k]);
                end
                if (s_valid[k] && s_ready) begin
                    have = (k == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
                    if (!have) begin
                        n_tests++;
                        fail("spurious_word", k, s_data[k], 0);
                    end else begin
                        if (k == 0) exp_w = eq0.pop_front();
                        else        exp_w = eq1.pop_front();
                        check("stream_data", k, s_data[k], exp_w);
                    end
                    outst[k]--;
                end
                if (s_pop[k]) outst[k]++;
                if (outst[k] > k + 3) fail("credit", k, outst[k], k + 3);
                if (s_valid[k] && !s_ready) stall_m[k]++;
            end
            prev_valid[k] = s_valid[k];
            prev_data[k]  = s_data[k];
        end
        prev_ready = s_ready;
        prev_flush = s_flush;
        prev_rstn  = s_rstn;
    endtask

    // Clock edge: FIFO model returns popped words after its latency.
    task automatic advance();
        logic [31:0] w;
        @(posedge clk);
        #1;
        w = $urandom;
        if (!s_rstn || s_flush) begin
            fq0.delete(); eq0.delete(); outst[0] = 0;
        end else if (s_pop[0] && fq0.size() > 0) begin
            w = fq0.pop_front();
        end
        fdata0 = w;
        w = $urandom;
        if (!s_rstn || s_flush) begin
            fq1.delete(); eq1.delete(); outst[1] = 0;
        end else if (s_pop[1] && fq1.size() > 0) begin
            w = fq1.pop_front();
        end
        fdata1 = pipe1;
        pipe1  = w;
        if (!s_rstn) begin
            stall_m[0] = 0;
            stall_m[1] = 0;
        end
        empty0  = (fq0.size() == 0);
        empty1  = (fq1.size() == 0);
        flush_d = s_flush;
        rst_d   = !s_rstn;
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        bit done;
        done  = 1'b0;
        ready = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            sample();
            done = (eq0.size() == 0) && (eq1.size() == 0) && !s_valid[0] && !s_valid[1];
            advance();
        end
        check(name, 0, eq0.size(), 0);
        check(name, 1, eq1.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pp[2], pv[2], npop[2], nh[2], first[2], last[2];
        logic [31:0] vd[2];
        logic        got_first[2];

        for (int k = 0; k < 2; k++) begin
            outst[k] = 0; stall_m[k] = 0; prev_valid[k] = 1'b0; prev_data[k] = '0;
        end
        for (int c = 0; c < 22; c++) begin
            vecs[c].ready = 1'b1;
            vecs[c].pop1  = (c >= 1 && c <= 16);
            vecs[c].val1  = (c >= 3 && c <= 18);
            vecs[c].d1    = vecs[c].val1 ? 32'(32'h10 + c - 3) : 32'h0;
            vecs[c].pop2  = (c >= 1 && c <= 16);
            vecs[c].val2  = (c >= 4 && c <= 19);
            vecs[c].d2    = vecs[c].val2 ? 32'(32'h10 + c - 4) : 32'h0;
        end
        @(negedge clk);

        // Streaming from reset, both latencies, table-driven.
        do_reset();
        for (int i = 0; i < 16; i++) push(32'(32'h10 + i));
        for (int c = 0; c < 22; c++) begin
            ready = vecs[c].ready;
            sample();
            check("vec_ctrl", 0, {30'd0, s_pop[0], s_valid[0]}, {30'd0, vecs[c].pop1, vecs[c].val1});
            check("vec_data", 0, s_valid[0] ? s_data[0] : 32'h0, vecs[c].d1);
            check("vec_ctrl", 1, {30'd0, s_pop[1], s_valid[1]}, {30'd0, vecs[c].pop2, vecs[c].val2});
            check("vec_data", 1, s_valid[1] ? s_data[1] : 32'h0, vecs[c].d2);
            advance();
        end

        // Refill after empty: pop-to-valid is READ_LATENCY+1.
        push(32'hAB);
        pp[0] = -1; pp[1] = -1; pv[0] = -1; pv[1] = -1; vd[0] = '0; vd[1] = '0;
        for (int c = 0; c < 10; c++) begin
            sample();
            for (int k = 0; k < 2; k++) begin
                if (s_pop[k] && pp[k] < 0) pp[k] = c;
                if (s_valid[k] && pv[k] < 0) begin
                    pv[k] = c;
                    vd[k] = s_data[k];
                end
            end
            advance();
        end
        check("refill_lat", 0, pv[0] - pp[0], 2);
        check("refill_lat", 1, pv[1] - pp[1], 3);
        check("refill_data", 0, vd[0], 32'hAB);
        check("refill_data", 1, vd[1], 32'hAB);

        // Backpressure from the start: pops stop at BUF_DEPTH.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'(32'h20 + i));
        npop[0] = 0; npop[1] = 0;
        for (int c = 0; c < 12; c++) begin
            sample();
            for (int k = 0; k < 2; k++) npop[k] += int'(s_pop[k]);
            advance();
        end
        check("bp_pops", 0, npop[0], 3);
        check("bp_pops", 1, npop[1], 4);
        check("bp_pop_idle", 0, s_pop[0], 0);
        check("bp_pop_idle", 1, s_pop[1], 0);
        ready = 1'b1;
        nh[0] = 0; nh[1] = 0; first[0] = -1; first[1] = -1; last[0] = 0; last[1] = 0;
        for (int c = 0; c < 20; c++) begin
            sample();
            for (int k = 0; k < 2; k++) begin
                if (s_valid[k] && s_ready) begin
                    nh[k]++;
                    if (first[k] < 0) first[k] = c;
                    last[k] = c;
                end
            end
            advance();
        end
        check("bp_count", 0, nh[0], 10);
        check("bp_count", 1, nh[1], 10);
        check("bp_gap", 0, last[0] - first[0], 9);
        check("bp_gap", 1, last[1] - first[1], 9);

        // Flush with words both in flight and buffered.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'(32'h30 + i));
        repeat (5) tick();
        flush = 1'b1;
        sample();
        check("pre_flush_valid", 1, s_valid[1], 1);
        advance();
        flush = 1'b0;
        push(32'hC0);
        push(32'hC1);
        sample();
        for (int k = 0; k < 2; k++) begin
            check("flush_valid", k, s_valid[k], 0);
            check("flush_pop", k, s_pop[k], 0);
        end
        advance();
        ready = 1'b1;
        got_first[0] = 1'b0; got_first[1] = 1'b0; vd[0] = '0; vd[1] = '0;
        for (int c = 0; c < 10; c++) begin
            sample();
            for (int k = 0; k < 2; k++) begin
                if (s_valid[k] && !got_first[k]) begin
                    got_first[k] = 1'b1;
                    vd[k] = s_data[k];
                end
            end
            advance();
        end
        check("post_flush_first", 0, vd[0], 32'hC0);
        check("post_flush_first", 1, vd[1], 32'hC0);
        drain("flush_drain");

        // Reset in the middle of a stream.
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) push(32'(32'h40 + i));
        repeat (6) tick();
        do_reset();
        sample();
        for (int k = 0; k < 2; k++) begin
            check("rst_valid", k, s_valid[k], 0);
            check("rst_pop", k, s_pop[k], 0);
            check("rst_data", k, s_data[k], 0);
            check("rst_stall", k, s_stall[k], 0);
        end
        advance();
        for (int i = 0; i < 4; i++) push(32'(32'h50 + i));
        drain("rst_drain");

        // Stall counter: seven backpressure cycles, then a flush.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'(32'h60 + i));
        for (int c = 0; c < 30 && stall_m[0] < 7; c++) tick();
        ready = 1'b1;
        sample();
        check("stall_cnt", 0, s_stall[0], PERF ? 32'd7 : 32'd0);
        advance();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sample();
        check("stall_after_flush", 0, s_stall[0], PERF ? 32'd7 : 32'd0);
        advance();
        drain("perf_drain");

        // Randomized traffic against the stream model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 59) == 0);
            if (!flush && $urandom_range(0, 2) != 0 && fq0.size() < 20) push($urandom);
            tick();
        end
        flush = 1'b0;
        drain("rand_drain");
        check("rand_stall", 0, s_stall[0], PERF ? 32'(stall_m[0]) : 32'd0);
        check("rand_stall", 1, s_stall[1], PERF ? 32'(stall_m[1]) : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_fifo_reader.md
# sram_fifo_reader

Pop-side reader for the BRAM-backed synchronous FIFO. It issues pops into the FIFO's pop/empty/data port and absorbs the macro's fixed read latency (data appears READ_LATENCY cycles after the pop). It presents the words downstream as a valid/ready stream at one word per cycle, and no downstream input has a combinational path to the FIFO side. It sits between the SRAM FIFO and any streaming consumer, such as a decode or commit stage.

## Interface
- DATA_WIDTH, 32, word width; must equal the FIFO data width.
- READ_LATENCY, 1, cycles from `fifo_pop_o` high to valid `fifo_data_i`; legal values 1 or 2 (2 when the output register is enabled).
- BUF_DEPTH (localparam), READ_LATENCY+2, number of skid buffer entries.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- flush_i  in  1  drop all buffered and in-flight words; the same signal drives the FIFO flush.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_pop_o  out  1  pop request to the FIFO.
- fifo_data_i  in  DATA_WIDTH  FIFO read data, valid READ_LATENCY cycles after a pop.
- valid_o  out  1  `data_o` holds a word.
- ready_i  in  1  consumer accepts the word.
- data_o  out  DATA_WIDTH  head word.
- stall_cnt_o  out  32  count of backpressure cycles (see Configuration).

## Operation
- **Internal state**
  - Pipeline `inflight_q[READ_LATENCY-1:0]`: one tag bit per outstanding pop, shifted every cycle.
  - Circular buffer: BUF_DEPTH entries, `rd_ptr`/`wr_ptr` of width $clog2(BUF_DEPTH), occupancy `cnt_q` of width $clog2(BUF_DEPTH+1).
  - `flush_q`: registered copy of `flush_i`.
- **Pop rule**
  - fifo_pop_o = !fifo_empty_i && !flush_i && !flush_q && (popcount(inflight_q) + cnt_q < BUF_DEPTH).
  - The rule is independent of `ready_i`.
  - Pops are suppressed in the flush cycle and the following cycle, because the FIFO applies flush one cycle late.
- **Return**
  - When the tag leaving the pipeline is 1, `fifo_data_i` is written at `wr_ptr` and `wr_ptr` advances.
  - The credit rule guarantees the buffer never overflows. Overflow is an assertion failure.
- **Output**
  - valid_o = (cnt_q != 0); data_o = buf[rd_ptr].
  - A handshake is valid_o && ready_i; on a handshake `rd_ptr` advances.
  - A write and a handshake in the same cycle leave `cnt_q` unchanged.
- **Pointer wrap**
  - Pointers wrap from BUF_DEPTH-1 to 0. BUF_DEPTH need not be a power of two, so the wrap is an explicit compare, not natural overflow.
- **Flush** (has priority over everything except reset)
  - Clears `cnt_q`, both pointers and all `inflight_q` tags at the next edge.
  - Data returning for pops issued before or during the flush is discarded.
  - A handshake in the flush cycle is still counted as delivered to the consumer.
- **Reset**, applied at the rising edge while rst_ni=0:
  - valid_o=0, fifo_pop_o=0 (combinationally, since cnt and tags are 0 and flush_q is reset to 1), data_o=0 (buffer entries cleared).
  - stall_cnt_o=0, all pointers and counts 0, flush_q=1.
  - flush_q=1 blocks pops during the first cycle after reset, while the FIFO settles.

## Timing
- Pop in cycle t → data in buffer at edge end of t+READ_LATENCY → valid_o in cycle t+READ_LATENCY+1.
- Pop-to-valid latency is READ_LATENCY+1; empty-to-first-valid latency is the same.
- Throughput is 1 word/cycle sustained with ready_i=1 and the FIFO non-empty.
- When ready_i drops, at most BUF_DEPTH words are held and popping stops. When ready_i returns, full rate resumes with no bubble.
- valid_o is never retracted without a handshake or flush. data_o is stable while valid_o && !ready_i.
- fifo_pop_o depends only on registers, fifo_empty_i and flush_i.

## Configuration
- `SRAM_FIFO_READER_PERF_EN`
- **Defined:** `stall_cnt_o` increments by 1 each cycle with valid_o=1 and ready_i=0.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared by reset only, not by flush.
- **Undefined:** no counter logic is built; `stall_cnt_o` is tied to 32'h0.

## Test plan
- **Streaming, READ_LATENCY=1:** FIFO preloaded with 0x10..0x1F, ready_i=1 → first pop at cycle 1 after reset release. valid_o rises 2 cycles after the first pop. 16 words arrive in order on consecutive cycles.
- **Backpressure, READ_LATENCY=2:** ready_i=0 from start, FIFO holds 10 words → exactly 4 pops (BUF_DEPTH=4), then fifo_pop_o=0. After ready_i=1, all 10 words arrive in order with no gap after the first.
- **Empty/refill:** FIFO empties mid-stream → valid_o drops after the last word. A new push of 0xAB → valid_o with 0xAB READ_LATENCY+1 cycles after its pop.
- **Flush with 2 pops in flight and 2 words buffered:**
  - valid_o=0 next cycle.
  - In-flight data is never output.
  - fifo_pop_o=0 for the flush cycle plus one.
  - The first post-flush word is the first word pushed after the flush.
- **Reset mid-stream** (rst_ni=0 for 1 cycle): all outputs 0 at the next edge; the stream restarts cleanly with no stale data.
- **With PERF_EN:** 7 cycles of valid_o=1, ready_i=0 → stall_cnt_o=7. A flush leaves it at 7. Without the macro it reads 0.
